// File: rtl/ghost_collision_ctrl.sv
// Per-frame game-state controller: ghost contact detection, life accounting and
// PLAY / DYING / GAME_OVER / WON sequencing, with hold and recentre controls for the movers.
module ghost_collision_ctrl #(
    parameter int NUM_LIVES      = 3,
    parameter int HIT_DIST       = 12,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] PacX,
    input  logic [9:0] PacY,
    input  logic [9:0] RedghostX,
    input  logic [9:0] RedghostY,
    input  logic [9:0] PinkghostX,
    input  logic [9:0] PinkghostY,
    input  logic [9:0] BlueghostX,
    input  logic [9:0] BlueghostY,
    input  logic [9:0] OrangeghostX,
    input  logic [9:0] OrangeghostY,
    input  logic [3:0] ghost_en,
    input  logic [8:0] dots_left,
    output logic [2:0] lives,
    output logic       freeze,
    output logic       respawn,
    output logic       game_over,
    output logic       game_won,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_DYING = 2'd1,
        S_OVER  = 2'd2,
        S_WON   = 2'd3
    } state_t;

    localparam logic [10:0] HIT_D      = 11'(HIT_DIST);
    localparam logic [2:0]  LIVES_INIT = 3'(NUM_LIVES);
    localparam logic [7:0]  TIMER_LOAD = 8'(RESPAWN_FRAMES - 1);

    // Absolute per-axis distance, widened by one bit so thresholds above 1023 still compare correctly.
    function automatic logic axis_near(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return ({1'b0, d} < HIT_D);
    endfunction

    function automatic logic ghost_hit(input logic       en,
                                       input logic [9:0] px, input logic [9:0] py,
                                       input logic [9:0] gx, input logic [9:0] gy);
        return en && axis_near(px, gx) && axis_near(py, gy);
    endfunction

    logic [3:0] w_hit;
    logic       w_any_hit;

    assign w_hit[0]  = ghost_hit(ghost_en[0], PacX, PacY, RedghostX,    RedghostY);
    assign w_hit[1]  = ghost_hit(ghost_en[1], PacX, PacY, PinkghostX,   PinkghostY);
    assign w_hit[2]  = ghost_hit(ghost_en[2], PacX, PacY, BlueghostX,   BlueghostY);
    assign w_hit[3]  = ghost_hit(ghost_en[3], PacX, PacY, OrangeghostX, OrangeghostY);
    assign w_any_hit = |w_hit;

    state_t     r_state;
    logic [2:0] r_lives;
    logic [7:0] r_timer;
    logic       r_freeze;
    logic       r_respawn;
    logic       r_game_over;
    logic       r_game_won;

    // Game FSM with registered outputs; respawn is a one-frame pulse defaulting low.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_PLAY;
            r_lives     <= LIVES_INIT;
            r_timer     <= 8'd0;
            r_freeze    <= 1'b0;
            r_respawn   <= 1'b0;
            r_game_over <= 1'b0;
            r_game_won  <= 1'b0;
        end else begin
            r_respawn <= 1'b0;
            case (r_state)
                S_PLAY: begin
                    if (dots_left == 9'd0) begin
                        r_state    <= S_WON;
                        r_game_won <= 1'b1;
                        r_freeze   <= 1'b1;
                    end else if (w_any_hit && (r_lives > 3'd1)) begin
                        r_state  <= S_DYING;
                        r_lives  <= r_lives - 3'd1;
                        r_timer  <= TIMER_LOAD;
                        r_freeze <= 1'b1;
                    end else if (w_any_hit) begin
                        r_state     <= S_OVER;
                        r_lives     <= 3'd0;
                        r_game_over <= 1'b1;
                        r_freeze    <= 1'b1;
                    end else begin
                        r_freeze <= 1'b0;
                    end
                end
                S_DYING: begin
                    if (r_timer == 8'd0) begin
                        r_state   <= S_PLAY;
                        r_respawn <= 1'b1;
                        r_freeze  <= 1'b0;
                    end else begin
                        r_timer  <= r_timer - 8'd1;
                        r_freeze <= 1'b1;
                    end
                end
                S_OVER: begin
                    r_freeze <= 1'b1;
                end
                S_WON: begin
                    r_freeze <= 1'b1;
                end
                default: begin
                    r_state  <= S_PLAY;
                    r_freeze <= 1'b0;
                end
            endcase
        end
    end

    assign lives     = r_lives;
    assign freeze    = r_freeze;
    assign respawn   = r_respawn;
    assign game_over = r_game_over;
    assign game_won  = r_game_won;
    assign state     = r_state;

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Directed bench for ghost_collision_ctrl: reset defaults, hit threshold, respawn timing,
// game over, win priority and reset during DYING. A second instance runs with a one-frame DYING.
module tb_ghost_collision_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [9:0] PacX, PacY;
    logic [9:0] RedX, RedY, PinkX, PinkY, BlueX, BlueY, OrgX, OrgY;
    logic [3:0] ghost_en;
    logic [8:0] dots_left;

    logic [2:0] lives,  d1_lives;
    logic       freeze, d1_freeze;
    logic       respawn, d1_respawn;
    logic       game_over, d1_game_over;
    logic       game_won, d1_game_won;
    logic [1:0] state, d1_state;

    int errors = 0;
    int checks = 0;

    always #5 frame_clk = ~frame_clk;

    ghost_collision_ctrl #(.NUM_LIVES(3), .HIT_DIST(12), .RESPAWN_FRAMES(60)) u_dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .PacX(PacX), .PacY(PacY),
        .RedghostX(RedX), .RedghostY(RedY), .PinkghostX(PinkX), .PinkghostY(PinkY),
        .BlueghostX(BlueX), .BlueghostY(BlueY), .OrangeghostX(OrgX), .OrangeghostY(OrgY),
        .ghost_en(ghost_en), .dots_left(dots_left),
        .lives(lives), .freeze(freeze), .respawn(respawn),
        .game_over(game_over), .game_won(game_won), .state(state)
    );

    ghost_collision_ctrl #(.NUM_LIVES(3), .HIT_DIST(12), .RESPAWN_FRAMES(1)) u_dut1 (
        .frame_clk(frame_clk), .Reset(Reset),
        .PacX(PacX), .PacY(PacY),
        .RedghostX(RedX), .RedghostY(RedY), .PinkghostX(PinkX), .PinkghostY(PinkY),
        .BlueghostX(BlueX), .BlueghostY(BlueY), .OrangeghostX(OrgX), .OrangeghostY(OrgY),
        .ghost_en(ghost_en), .dots_left(dots_left),
        .lives(d1_lives), .freeze(d1_freeze), .respawn(d1_respawn),
        .game_over(d1_game_over), .game_won(d1_game_won), .state(d1_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic ghosts_away();
        RedX = 10'd0;   RedY = 10'd0;
        PinkX = 10'd0;  PinkY = 10'd0;
        BlueX = 10'd0;  BlueY = 10'd0;
        OrgX = 10'd0;   OrgY = 10'd0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #3;
        @(negedge frame_clk);
        Reset = 1'b0;
        #1;
    endtask

    task automatic chk_defaults(input string tag);
        chk({tag, "_lives"},   32'(lives),     32'd3);
        chk({tag, "_state"},   32'(state),     32'd0);
        chk({tag, "_freeze"},  32'(freeze),    32'd0);
        chk({tag, "_respawn"}, 32'(respawn),   32'd0);
        chk({tag, "_over"},    32'(game_over), 32'd0);
        chk({tag, "_won"},     32'(game_won),  32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        PacX = 10'd328; PacY = 10'd248;
        ghosts_away();
        ghost_en  = 4'b0000;
        dots_left = 9'd100;
        #12;
        chk_defaults("reset");
        do_reset();
        chk_defaults("reset_rel");

        // Threshold: distance 12 is not a hit, disabled ghost is not a hit
        BlueX = 10'd340; BlueY = 10'd248; ghost_en = 4'b0100;
        tick();
        chk("dist12_state", 32'(state), 32'd0);
        chk("dist12_lives", 32'(lives), 32'd3);
        BlueX = 10'd339; ghost_en = 4'b0000;
        tick();
        chk("dis_state", 32'(state), 32'd0);
        chk("dis_lives", 32'(lives), 32'd3);

        // Distance 11 enabled: hit at edge N, ghost left overlapping
        ghost_en = 4'b0100;
        tick();
        chk("hit1_lives",   32'(lives),   32'd2);
        chk("hit1_state",   32'(state),   32'd1);
        chk("hit1_freeze",  32'(freeze),  32'd1);
        chk("hit1_respawn", 32'(respawn), 32'd0);
        chk("d1_hit_state", 32'(d1_state), 32'd1);
        tick();
        chk("d1_back_state",   32'(d1_state),   32'd0);
        chk("d1_back_respawn", 32'(d1_respawn), 32'd1);
        chk("d1_back_freeze",  32'(d1_freeze),  32'd0);
        for (int i = 0; i < 58; i++) tick();
        chk("dying_n59_state", 32'(state),  32'd1);
        chk("dying_n59_lives", 32'(lives),  32'd2);
        chk("dying_n59_frz",   32'(freeze), 32'd1);
        tick();
        chk("resp_state",   32'(state),   32'd0);
        chk("resp_pulse",   32'(respawn), 32'd1);
        chk("resp_freeze",  32'(freeze),  32'd0);
        chk("resp_lives",   32'(lives),   32'd2);

        // Overlap still present: first hit test after respawn
        tick();
        chk("hit2_respawn", 32'(respawn), 32'd0);
        chk("hit2_lives",   32'(lives),   32'd1);
        chk("hit2_state",   32'(state),   32'd1);
        for (int i = 0; i < 60; i++) tick();
        chk("resp2_state", 32'(state),   32'd0);
        chk("resp2_pulse", 32'(respawn), 32'd1);
        tick();
        chk("over_lives",  32'(lives),     32'd0);
        chk("over_state",  32'(state),     32'd2);
        chk("over_flag",   32'(game_over), 32'd1);
        chk("over_freeze", 32'(freeze),    32'd1);
        dots_left = 9'd0;
        tick();
        tick();
        chk("over_hold_state", 32'(state),    32'd2);
        chk("over_hold_lives", 32'(lives),    32'd0);
        chk("over_hold_won",   32'(game_won), 32'd0);
        chk("over_hold_resp",  32'(respawn),  32'd0);

        // Win has priority over a simultaneous red hit
        do_reset();
        chk_defaults("reset2");
        ghosts_away();
        RedX = 10'd328; RedY = 10'd248; ghost_en = 4'b0001; dots_left = 9'd0;
        tick();
        chk("win_state",  32'(state),     32'd3);
        chk("win_flag",   32'(game_won),  32'd1);
        chk("win_lives",  32'(lives),     32'd3);
        chk("win_freeze", 32'(freeze),    32'd1);
        chk("win_over",   32'(game_over), 32'd0);
        dots_left = 9'd50;
        tick();
        chk("win_hold_state", 32'(state), 32'd3);
        chk("win_hold_lives", 32'(lives), 32'd3);

        // Reset in the middle of DYING
        do_reset();
        tick();
        chk("dying_re_state", 32'(state), 32'd1);
        chk("dying_re_lives", 32'(lives), 32'd2);
        ghosts_away();
        for (int i = 0; i < 29; i++) tick();
        chk("mid_state", 32'(state), 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk_defaults("mid_reset");
        @(negedge frame_clk);
        Reset = 1'b0;
        tick();
        chk("mid_no_resp",  32'(respawn), 32'd0);
        chk("mid_no_state", 32'(state),   32'd0);

        // Four simultaneous hits cost one life and restart a full DYING count
        RedX = 10'd330;  RedY = 10'd250;
        PinkX = 10'd320; PinkY = 10'd240;
        BlueX = 10'd328; BlueY = 10'd259;
        OrgX = 10'd317;  OrgY = 10'd237;
        ghost_en = 4'b1111;
        tick();
        chk("multi_lives", 32'(lives), 32'd2);
        chk("multi_state", 32'(state), 32'd1);
        ghosts_away();
        for (int i = 0; i < 59; i++) tick();
        chk("full_n59_state", 32'(state), 32'd1);
        tick();
        chk("full_resp_state", 32'(state),   32'd0);
        chk("full_resp_pulse", 32'(respawn), 32'd1);
        tick();
        chk("full_resp_end",   32'(respawn), 32'd0);
        chk("full_lives",      32'(lives),   32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ghost_collision_ctrl.md
# ghost_collision_ctrl

Per-frame game-state controller that sits directly downstream of the four ghost movers and the Pac-Man mover. On every `frame_clk` edge it compares Pac-Man's centre position against each enabled ghost's centre position, decrements lives on contact, and sequences the game through play, death/respawn, game-over and win states. Its `freeze` and `respawn` outputs feed back into the movers as hold and recentre controls. Its `game_over`, `game_won` and `lives` outputs drive the HUD/text overlay.

## Interface
Parameters:
- `NUM_LIVES`, 3: starting life count; legal range 1–7.
- `HIT_DIST`, 12: contact threshold in pixels, applied per axis with strict less-than.
- `RESPAWN_FRAMES`, 60: frames spent in DYING before play resumes; legal range 1–255.

Ports:
- `frame_clk`  in  1  frame clock (vsync); the only clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `PacX`, `PacY`  in  10 each  Pac-Man centre position.
- `RedghostX`, `RedghostY`, `PinkghostX`, `PinkghostY`, `BlueghostX`, `BlueghostY`, `OrangeghostX`, `OrangeghostY`  in  10 each  ghost centre positions.
- `ghost_en`  in  4  per-ghost collision enable; bit order is [0]=red, [1]=pink, [2]=blue, [3]=orange.
- `dots_left`  in  9  remaining dot count from the maze/dot tracker.
- `lives`  out  3  current life count.
- `freeze`  out  1  movers hold position while high.
- `respawn`  out  1  single-frame pulse telling the movers to reload their start positions.
- `game_over`  out  1  lives exhausted.
- `game_won`  out  1  all dots eaten.
- `state`  out  2  encoding is PLAY=0, DYING=1, GAME_OVER=2, WON=3.

## Operation
- Per-ghost hit test:
  - dx = (PacX ≥ GX) ? PacX−GX : GX−PacX, computed as 10-bit unsigned with no wrap; dy is computed the same way.
  - hit_i = ghost_en[i] && dx < HIT_DIST && dy < HIT_DIST.
  - any_hit is the OR of all four hit_i.
  - The hit test is combinational on the current inputs and is sampled at the `frame_clk` edge.
- PLAY:
  - If dots_left == 0: go to WON and set game_won=1. This check has priority over a hit in the same frame.
  - Else if any_hit and lives > 1: lives−1, go to DYING, set timer = RESPAWN_FRAMES−1.
  - Else if any_hit and lives == 1: set lives=0, go to GAME_OVER, set game_over=1.
  - Multiple simultaneous ghost hits cost exactly one life.
- DYING:
  - freeze=1. Hits and dots_left are ignored.
  - The 8-bit timer decrements once per frame.
  - When timer == 0 at an edge: go to PLAY and assert respawn for exactly one frame; freeze=0 from that same edge.
- GAME_OVER and WON are terminal: freeze=1, all inputs ignored, exit only via Reset.
- `freeze` = (state != PLAY), registered. `respawn` is registered and high only in the frame immediately after DYING→PLAY.
- Reset (asynchronous, any state, including mid-DYING):
  - state=PLAY, lives=NUM_LIVES, timer=0.
  - freeze=0, respawn=0, game_over=0, game_won=0.
  - A pending respawn pulse is discarded.

## Timing
- All outputs are registered on the `frame_clk` rising edge. An input condition present at edge N is reflected on the outputs immediately after edge N (zero-frame latency); there is no additional pipeline.
- A DYING entry at edge N causes the return to PLAY at edge N+RESPAWN_FRAMES. respawn is high between edges N+RESPAWN_FRAMES and N+RESPAWN_FRAMES+1.
- With RESPAWN_FRAMES=1, DYING lasts exactly one frame.
- A hit present at the DYING→PLAY edge is ignored. The first hit test after respawn occurs at the following edge.
- Reset deassertion needs no synchronisation beyond the `frame_clk` domain. The first state update happens at the first edge with Reset low.

## Test plan
- **Reset defaults:** pulse Reset with NUM_LIVES=3 → lives=3, state=0, freeze=0, respawn=0, game_over=0, game_won=0.
- **Threshold boundary:** Pac=(328,248), blue=(339,248), ghost_en=4'b0100 → hit; lives 3→2, state=1, freeze=1. Move blue to (340,248) after Reset → no hit. Same ghost at (339,248) with ghost_en=0 → no hit.
- **Respawn sequence:** RESPAWN_FRAMES=60; hit at edge 5 → state=1 during edges 5–64. state=0 and respawn=1 for exactly one frame after edge 65; respawn=0 after edge 66. A ghost left overlapping during DYING causes no further life loss.
- **Game over:** three hits separated by respawns → lives=0, state=2, game_over=1, freeze=1. Further hits and dots_left=0 leave all outputs unchanged.
- **Win priority:** dots_left=0 in the same frame as a red ghost hit → state=3, game_won=1, lives unchanged at 3.
- **Reset mid-DYING:** assert Reset with timer=30 → outputs return to defaults immediately, with no respawn pulse. The next hit restarts DYING with a full RESPAWN_FRAMES count.
